// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_t          : fetch FSM state encoding
//   KIND_*           : redirect_kind encodings
//   DEFAULT_PC_W     : default PC / address width
//   DEFAULT_INSTR_W  : default instruction width
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DELIVER = 2'b10
    } state_t;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_CALL   = 2'b10;
    localparam logic [1:0] KIND_RETURN = 2'b11;

    localparam int DEFAULT_PC_W    = 10;
    localparam int DEFAULT_INSTR_W = 16;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack.
// A push while full overwrites the oldest entry; the count saturates at DEPTH.
// A pop while empty is ignored (the caller decides what an empty pop means).
// Ports:
//   clk, reset_n      : clock, async active-low reset (clears the stack)
//   push, push_data   : write push_data on top of the stack
//   pop               : discard the top entry
//   pop_data          : current top entry (valid when !empty)
//   empty, full       : occupancy status
module return_addr_stack
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_PC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full
);

    // DEPTH is a power of two >= 2, so the pointer wraps naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // Next free slot. When the stack is full this slot holds the oldest
    // entry, which is exactly the one a push must overwrite.
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     top_idx;
    logic [CW-1:0]     count;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign top_idx  = wr_ptr - PTR_ONE;
    assign pop_data = mem[top_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (!full) begin
                count <= count + CNT_ONE;
            end
        end else if (pop && !empty) begin
            wr_ptr <= top_idx;
            count  <= count - CNT_ONE;
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests instructions from memory one at a
// time, hands each to the decoder, and applies control-flow redirects
// (relative branch, absolute jump, call, return) using a return-address stack.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | just out of reset; leaves for ST_FETCH on the next clock
// ST_FETCH   | imem_req high at imem_addr = pc, waiting for imem_ack
// ST_DELIVER | instr/instr_pc held with instr_valid high until decode_ready
//
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   imem_req, imem_addr               : memory read request / address (= pc)
//   imem_ack, imem_rdata              : memory response
//   instr_valid, instr, instr_pc      : instruction handed to the decoder
//   decode_ready                      : decoder accepts instr
//   redirect_valid/kind/target        : control-flow change request
//   ras_overflow, ras_underflow       : sticky stack error flags
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W      = DEFAULT_PC_W,
    parameter int              INSTR_W   = DEFAULT_INSTR_W,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               decode_ready,
    input  logic               redirect_valid,
    input  logic [1:0]         redirect_kind,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t             state, state_next;
    logic [PC_W-1:0]    pc, pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic [PC_W-1:0]    instr_pc_next;
    logic               ovf_set, udf_set;

    logic               ras_push, ras_pop;
    logic [PC_W-1:0]    ras_push_data, ras_pop_data;
    logic               ras_empty, ras_full;

    return_addr_stack #(
        .DEPTH  (RAS_DEPTH),
        .DATA_W (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push),
        .push_data (ras_push_data),
        .pop       (ras_pop),
        .pop_data  (ras_pop_data),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Request/valid come straight from the state register, so a redirect
    // in FETCH moves the address on the next cycle; the memory sees the
    // old request as aborted and any same-cycle ack is simply not consumed.
    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_DELIVER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            instr_pc      <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            instr         <= instr_next;
            instr_pc      <= instr_pc_next;
            ras_overflow  <= ras_overflow | ovf_set;
            ras_underflow <= ras_underflow | udf_set;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = instr;
        instr_pc_next = instr_pc;
        ovf_set       = 1'b0;
        udf_set       = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_push_data = instr_pc + PC_ONE;

        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end

            ST_FETCH, ST_DELIVER: begin
                if (redirect_valid) begin
                    state_next = ST_FETCH;
                    case (redirect_kind)
                        KIND_BRANCH: pc_next = instr_pc + redirect_target;
                        KIND_JUMP:   pc_next = redirect_target;
                        KIND_CALL: begin
                            pc_next  = redirect_target;
                            ras_push = 1'b1;
                            ovf_set  = ras_full;
                        end
                        default: begin
                            if (ras_empty) begin
                                pc_next = RESET_PC;
                                udf_set = 1'b1;
                            end else begin
                                pc_next = ras_pop_data;
                                ras_pop = 1'b1;
                            end
                        end
                    endcase
                end else if (state == ST_FETCH) begin
                    if (imem_ack) begin
                        instr_next    = imem_rdata;
                        instr_pc_next = pc;
                        pc_next       = pc + PC_ONE;
                        state_next    = ST_DELIVER;
                    end
                end else if (decode_ready) begin
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [9:0]  instr_pc;
    logic        decode_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [9:0]  redirect_target;
    logic        ras_overflow;
    logic        ras_underflow;

    logic        auto_ack;
    logic        man_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory: zero-latency ack when auto_ack, otherwise manual.
    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = 16'hA000 ^ {6'd0, imem_addr};

    fetch_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .decode_ready    (decode_ready),
        .redirect_valid  (redirect_valid),
        .redirect_kind   (redirect_kind),
        .redirect_target (redirect_target),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [9:0] target);
        redirect_valid  = 1'b1;
        redirect_kind   = kind;
        redirect_target = target;
        step();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        auto_ack        = 1'b1;
        man_ack         = 1'b0;
        decode_ready    = 1'b1;
        redirect_valid  = 1'b0;
        redirect_kind   = 2'b00;
        redirect_target = '0;
        #1;
        chk("rst_req",   imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc",   instr_pc, 0);
        chk("rst_ovf",   ras_overflow, 0);
        chk("rst_udf",   ras_underflow, 0);
        step();
        step();
        chk("rst_hold_req", imem_req, 0);
        reset_n = 1'b1;
        step();

        // Back-to-back fetch: one instruction every two cycles.
        for (int k = 0; k < 4; k++) begin
            chk("seq_req",  imem_req, 1);
            chk("seq_addr", imem_addr, k);
            chk("seq_nov",  instr_valid, 0);
            step();
            chk("seq_valid", instr_valid, 1);
            chk("seq_ipc",   instr_pc, k);
            chk("seq_instr", instr, 32'hA000 + k);
            chk("seq_noreq", imem_req, 0);
            step();
        end

        // Delayed ack (3 cycles) then decoder stall (4 cycles).
        auto_ack     = 1'b0;
        decode_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("wait_req",  imem_req, 1);
            chk("wait_addr", imem_addr, 10'h004);
            step();
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr, 16'hA004);
            chk("stall_ipc",   instr_pc, 10'h004);
            step();
        end
        decode_ready = 1'b1;
        step();
        chk("resume_addr",  imem_addr, 10'h005);
        chk("resume_nov",   instr_valid, 0);

        // Jump to 0x3FE, then relative branch +5 wraps to 0x003.
        auto_ack     = 1'b1;
        decode_ready = 1'b0;
        redirect(2'b01, 10'h3FE);
        chk("jmp_addr", imem_addr, 10'h3FE);
        chk("jmp_nov",  instr_valid, 0);
        step();
        chk("br_src_ipc", instr_pc, 10'h3FE);
        redirect(2'b00, 10'h005);
        chk("br_wrap_addr", imem_addr, 10'h003);
        chk("br_nov",       instr_valid, 0);

        // Five calls from DELIVER: pushes 0x004, 0x011, 0x012, 0x013, 0x014.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("call_src_valid", instr_valid, 1);
            redirect(2'b10, 10'h010 + 10'(i));
            chk("call_addr", imem_addr, 10'h010 + i);
            chk("call_ovf",  ras_overflow, (i == 4) ? 1 : 0);
        end
        // Oldest entry (0x004) was overwritten; LIFO then underflow.
        for (int j = 0; j < 5; j++) begin
            redirect(2'b11, 10'h3FF);
            chk("ret_addr", imem_addr, (j < 4) ? (10'h014 - j) : 0);
            chk("ret_udf",  ras_underflow, (j == 4) ? 1 : 0);
            chk("ret_nov",  instr_valid, 0);
        end
        chk("ovf_sticky", ras_overflow, 1);

        // Redirect coinciding with ack: old data discarded.
        redirect(2'b01, 10'h200);
        chk("abort_addr", imem_addr, 10'h200);
        chk("abort_nov",  instr_valid, 0);
        auto_ack = 1'b0;
        step();
        chk("abort_nov2",  instr_valid, 0);
        chk("abort_addr2", imem_addr, 10'h200);

        // Reset pulse during DELIVER; redirect during IDLE must be ignored.
        auto_ack = 1'b1;
        step();
        chk("pre_rst_valid", instr_valid, 1);
        chk("pre_rst_ipc",   instr_pc, 10'h200);
        reset_n = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_req",   imem_req, 0);
        chk("async_instr", instr, 0);
        chk("async_ipc",   instr_pc, 0);
        chk("async_udf",   ras_underflow, 0);
        chk("async_ovf",   ras_overflow, 0);
        step();
        reset_n         = 1'b1;
        redirect_valid  = 1'b1;
        redirect_kind   = 2'b01;
        redirect_target = 10'h155;
        step();
        redirect_valid  = 1'b0;
        chk("restart_req",  imem_req, 1);
        chk("restart_addr", imem_addr, 0);
        step();
        chk("restart_valid", instr_valid, 1);
        chk("restart_ipc",   instr_pc, 0);
        chk("restart_instr", instr, 16'hA000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 10, PC and address width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two).
REQ-004 Parameter RESET_PC, default 0, PC loaded at reset and on return-underflow.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  PC_W  read address, equal to current pc.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  INSTR_W  instruction word, valid only with imem_ack.
REQ-011 instr_valid  output  1  instr/instr_pc hold a deliverable instruction.
REQ-012 instr  output  INSTR_W  fetched instruction.
REQ-013 instr_pc  output  PC_W  address of instr.
REQ-014 decode_ready  input  1  decoder accepts instr this cycle.
REQ-015 redirect_valid  input  1  control-flow change request, one-cycle pulse.
REQ-016 redirect_kind  input  2  00 relative branch, 01 absolute jump, 10 call, 11 return.
REQ-017 redirect_target  input  PC_W  offset (kind 00) or absolute target (01, 10); ignored for 11.
REQ-018 ras_overflow  output  1  sticky: push occurred while stack full.
REQ-019 ras_underflow  output  1  sticky: return occurred while stack empty.

Function
REQ-020 FSM states IDLE, FETCH, DELIVER shall exist; IDLE shall be left for FETCH on the first clock after reset_n deasserts.
REQ-021 In FETCH, imem_req shall be 1 and imem_addr shall equal pc, held stable until imem_ack or redirect.
REQ-022 FETCH with imem_ack and no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^PC_W), next state DELIVER.
REQ-023 In DELIVER, instr_valid shall be 1, imem_req 0; on decode_ready next state FETCH; instr/instr_pc shall not change while instr_valid=1 and decode_ready=0.
REQ-024 Fetch-to-fetch throughput: one instruction per 2 cycles minimum (ack same cycle as req, decode_ready immediate).
REQ-025 redirect_valid shall take priority over every other event in any non-IDLE state: next state FETCH, instr_valid cleared next cycle, any imem_ack same cycle discarded.
REQ-026 Withdrawing imem_req on redirect before imem_ack is legal; the memory shall treat it as an abort.
REQ-027 Kind 00: pc<=instr_pc+redirect_target, two's-complement, wrap mod 2^PC_W.
REQ-028 Kind 01: pc<=redirect_target.
REQ-029 Kind 10: push instr_pc+1 (wrapped) onto stack, pc<=redirect_target.
REQ-030 Kind 11: pop stack into pc; if empty, pc<=RESET_PC and ras_underflow<=1.
REQ-031 Push while full: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_overflow<=1.
REQ-032 redirect_valid in IDLE shall be ignored.
REQ-033 ras_overflow/ras_underflow clear only on reset.

Reset
REQ-034 reset_n=0 shall immediately force: state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, stack count=0, both sticky flags=0.
REQ-035 Reset asserted mid-fetch or mid-deliver shall discard the transaction; no imem_ack shall be consumed after reset deasserts until a new request.

Structure
REQ-036 Package fetch_pkg shall hold the state enum, the redirect_kind encoding constants, and default PC_W/INSTR_W.
REQ-037 Return stack shall be sub-module return_addr_stack (push, pop, data in/out, empty, full) with same clk/reset_n.

Verification
REQ-038 Reset release, ack after 0 cycles, decode_ready=1: instr_pc sequence 0,1,2,3 on successive instr_valid pulses every 2 cycles.
REQ-039 ack delayed 3 cycles, decode_ready held 0 for 4 cycles: imem_addr stable during wait, instr stable while stalled.
REQ-040 instr_pc=0x3FE, kind 00 target 0x005: next imem_addr=0x003 (wrap).
REQ-041 5 calls (targets 0x10..0x14) then 5 returns: ras_overflow=1, first 4 returns yield last 4 pushed addresses in LIFO order, 5th return yields RESET_PC with ras_underflow=1.
REQ-042 Redirect kind 01 target 0x200 coinciding with imem_ack: rdata discarded, next imem_addr=0x200, no instr_valid for old fetch.
REQ-043 reset_n pulsed low during DELIVER: instr_valid=0 immediately, fetch restarts at RESET_PC.
